uart_rx: RTL

//  Asynchronous serial receiver, 8N1, LSB first, idle-high line; companion to the core's UART transmitter.
//  16x oversampling with 3-sample majority vote at mid-bit; start-bit glitch rejection; framing/overrun flags.

---
 rtl/uart_rx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 2-of-3 majority vote at mid-bit, start-glitch
// rejection, sticky framing/overrun flags and a valid/ack output register.
module uart_rx #(
   parameter int unsigned FREQ     = 100000000,
   parameter int unsigned BAUDRATE = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RX_Serial,
   input  logic       RX_ACK,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       RX_BUSY,
   output logic       FRAME_ERR,
   output logic       OVERRUN
);
   localparam int unsigned OS_DIV = FREQ / (BAUDRATE * 16);
   localparam int unsigned CW     = $clog2(OS_DIV) + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state;
   logic          rx_meta, rx_s;
   logic [CW-1:0] tick_cnt;
   logic          os_tick, start_det, bit_tick;
   logic [3:0]    ph;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          s7, s8, maj;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX_Serial;
         rx_s    <= rx_meta;
      end
   end

   always_comb begin
      start_det = (state == IDLE) && !rx_s;
      os_tick   = (tick_cnt == CW'(OS_DIV - 1));
      bit_tick  = os_tick && ((state == START) || (state == DATA) || (state == STOP));
      maj       = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
   end

   // Restarting the divider on start detect aligns the oversample grid to the falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                     tick_cnt <= '0;
      else if (start_det || os_tick) tick_cnt <= '0;
      else                           tick_cnt <= tick_cnt + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ph        <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         s7        <= 1'b1;
         s8        <= 1'b1;
         RX_DATA   <= '0;
         RX_VALID  <= 1'b0;
         RX_BUSY   <= 1'b0;
         FRAME_ERR <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         if (RX_ACK) begin
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
         end
         if (bit_tick) begin
            ph <= ph + 4'd1;
            if (ph == 4'd7) s7 <= rx_s;
            if (ph == 4'd8) s8 <= rx_s;
         end
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state   <= START;
                  ph      <= '0;
                  RX_BUSY <= 1'b1;
               end
            end
            START: begin
               if (os_tick) begin
                  if (ph == 4'd9 && maj) begin
                     state   <= IDLE;
                     RX_BUSY <= 1'b0;
                  end else if (ph == 4'd15) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end
               end
            end
            DATA: begin
               if (os_tick) begin
                  if (ph == 4'd9) shreg <= {maj, shreg[7:1]};
                  if (ph == 4'd15) begin
                     if (bit_idx == 3'd7) state <= STOP;
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            STOP: begin
               // Leave right after the stop-bit vote rather than at bit end, to tolerate fast senders.
               if (ph >= 4'd10) begin
                  if (rx_s) begin
                     state   <= IDLE;
                     RX_BUSY <= 1'b0;
                  end else begin
                     state <= BREAK;
                  end
               end else if (os_tick && ph == 4'd9) begin
                  if (!maj) begin
                     FRAME_ERR <= 1'b1;
                  end else if (!RX_VALID || RX_ACK) begin
                     RX_DATA  <= shreg;
                     RX_VALID <= 1'b1;
                  end else begin
                     OVERRUN <= 1'b1;
                  end
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state   <= IDLE;
                  RX_BUSY <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
